// File: rtl/mem_slave_p.sv
// Parametrised register-file memory slave behind a four-phase req/ack handshake.
// Optional power-on memory clear is enabled by defining MEM_SLAVE_P_CLR_EN.
module mem_slave_p #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                cmd,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW     = 4;
  localparam logic [CntW-1:0] LatInit = CntW'(RD_LAT - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAccess = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StRet    = 3'd3;
  localparam logic [2:0] StClear  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IdxW-1:0]   idx;
  logic [DATA_W-1:0] merged;
  logic              mem_we;
  logic [IdxW-1:0]   mem_widx;
  logic [DATA_W-1:0] mem_wval;

`ifdef MEM_SLAVE_P_CLR_EN
  logic [IdxW-1:0]   clr_q, clr_d;
`endif

  // Full-width compare: out-of-range addresses must never alias onto real words.
  assign in_range = (64'(addr) < 64'(DEPTH));
  assign idx      = addr[IdxW-1:0];

  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < NumBytes; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    mem_widx = idx;
    mem_wval = merged;
`ifdef MEM_SLAVE_P_CLR_EN
    clr_d    = clr_q;
`endif
    case (state_q)
      StIdle: begin
        if (req) state_d = StAccess;
      end
      StAccess: begin
        if (!in_range) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = StRet;
        end else if (cmd) begin
          mem_we  = 1'b1;
          ack_d   = 1'b1;
          state_d = StRet;
        end else begin
          rdata_d = mem[idx];
          if (RD_LAT <= 1) begin
            ack_d   = 1'b1;
            state_d = StRet;
          end else begin
            cnt_d   = LatInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          ack_d   = 1'b1;
          state_d = StRet;
        end
      end
      StRet: begin
        if (!req) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
`ifdef MEM_SLAVE_P_CLR_EN
      StClear: begin
        mem_we   = 1'b1;
        mem_widx = clr_q;
        mem_wval = '0;
        if (clr_q == IdxW'(DEPTH - 1)) state_d = StIdle;
        else                           clr_d   = clr_q + 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef MEM_SLAVE_P_CLR_EN
      state_q <= StClear;
      clr_q   <= '0;
`else
      state_q <= StIdle;
`endif
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef MEM_SLAVE_P_CLR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // A reset edge never commits a write, even one that was in flight.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_widx] <= mem_wval;
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_slave_p.sv
// Self-checking bench for mem_slave_p (RD_LAT=2) using a reference memory and a scoreboard queue.
// Also covers the MEM_SLAVE_P_CLR_EN clear sweep when that macro is defined.
module tb_mem_slave_p;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 8;
  localparam int unsigned Depth = 16;
  localparam int unsigned RdLat = 2;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        cmd;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model [Depth];
  logic [31:0] last_rdata;
  exp_t        sb[$];

  mem_slave_p #(
    .DATA_W(DataW),
    .ADDR_W(AddrW),
    .DEPTH (Depth),
    .RD_LAT(RdLat)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .cmd  (cmd),
    .addr (addr),
    .wdata(wdata),
    .be   (be),
    .ack  (ack),
    .rdata(rdata),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge, check the reset values, then release (and wait out any clear sweep).
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    step();
    check("rst_ack", ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    last_rdata = 32'h0;
    rst_n = 1'b1;
`ifdef MEM_SLAVE_P_CLR_EN
    repeat (Depth) step();
    for (int i = 0; i < Depth; i++) model[i] = 32'h0;
`endif
  endtask

  // Full transaction: expectation pushed on drive, popped and compared on ack.
  task automatic txn(input logic c, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] b, input int hold);
    exp_t e;
    int   n;
    e.err = (a >= Depth);
    e.lat = (e.err || c) ? 2 : RdLat + 1;
    if (e.err)  e.rdata = 32'h0;
    else if (c) e.rdata = last_rdata;
    else        e.rdata = model[a];
    if (c && !e.err) begin
      for (int i = 0; i < 4; i++) if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
    end
    last_rdata = e.rdata;
    sb.push_back(e);
    cmd = c; addr = a; wdata = d; be = b; req = 1'b1;
    n = 0;
    while (ack !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    e = sb.pop_front();
    check("ack_latency", n, e.lat);
    check("err", err, e.err);
    check("rdata", rdata, e.rdata);
    for (int i = 0; i < hold; i++) begin
      step();
      check("ack_hold", ack, 1'b1);
    end
    req = 1'b0;
    step();
    check("ack_fall", ack, 1'b0);
    check("err_clear", err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; req = 1'b0; cmd = 1'b0; addr = '0; wdata = '0; be = '0;
    last_rdata = 32'h0;
    step();
    do_reset();

    // Give every word a known value.
    for (int i = 0; i < Depth; i++) txn(1'b1, 8'(i), 32'hA5000000 + 32'(i * 32'h01010101), 4'hF, 0);

    txn(1'b1, 8'd3, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 8'd3, 32'h0, 4'h0, 0);

    txn(1'b1, 8'd5, 32'h11223344, 4'hF, 0);
    txn(1'b1, 8'd5, 32'hAABBCCDD, 4'h5, 0);
    txn(1'b0, 8'd5, 32'h0, 4'h0, 0);
    txn(1'b1, 8'd5, 32'h99999999, 4'h0, 0);
    txn(1'b0, 8'd5, 32'h0, 4'h0, 0);

    txn(1'b0, 8'd16, 32'h0, 4'h0, 0);
    txn(1'b1, 8'd200, 32'hCAFEF00D, 4'hF, 0);
    txn(1'b1, 8'd255, 32'h12345678, 4'hF, 0);
    for (int i = 0; i < Depth; i++) txn(1'b0, 8'(i), 32'h0, 4'h0, 0);

    txn(1'b0, 8'd7, 32'h0, 4'h0, 5);
    txn(1'b1, 8'd7, 32'h0F0F0F0F, 4'hC, 3);

    // Early drop while in WAIT: ack must be a one-cycle pulse.
    e.err = 1'b0; e.rdata = model[9]; e.lat = RdLat + 1;
    sb.push_back(e);
    cmd = 1'b0; addr = 8'd9; req = 1'b1;
    step();
    step();
    req = 1'b0;
    step();
    e = sb.pop_front();
    check("early_ack", ack, 1'b1);
    check("early_rdata", rdata, e.rdata);
    last_rdata = e.rdata;
    step();
    check("early_ack_pulse", ack, 1'b0);
    txn(1'b0, 8'd3, 32'h0, 4'h0, 0);

    // Reset while the read waits out its latency.
    cmd = 1'b0; addr = 8'd3; req = 1'b1;
    step();
    step();
    do_reset();
    txn(1'b0, 8'd3, 32'h0, 4'h0, 0);
    txn(1'b0, 8'd5, 32'h0, 4'h0, 0);

`ifdef MEM_SLAVE_P_CLR_EN
    begin
      int n;
      for (int i = 0; i < Depth; i++) txn(1'b1, 8'(i), 32'hFFFFFFFF, 4'hF, 0);
      rst_n = 1'b0; req = 1'b0;
      step();
      rst_n = 1'b1; cmd = 1'b0; addr = 8'd0; req = 1'b1;
      n = 0;
      while (ack !== 1'b1 && n < 60) begin
        step();
        n++;
      end
      check("clr_latency", n, Depth + RdLat + 1);
      check("clr_rdata0", rdata, 32'h0);
      req = 1'b0;
      step();
      for (int i = 0; i < Depth; i++) model[i] = 32'h0;
      last_rdata = 32'h0;
      for (int i = 1; i < Depth; i++) txn(1'b0, 8'(i), 32'h0, 4'h0, 0);
    end
`endif

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_slave_p.md
Name: mem_slave_p

Overview:
- Parametrised successor of the single-channel 32-bit x16 memory slave.
- Register-file memory behind a four-phase req/ack handshake.
- Adds generic width, depth and read latency, byte-enable writes, an out-of-range error response, synchronous reset and optional memory clear.
- Sits on the master/slave test fabric as the target of one master.

Parameters:
DATA_W, 32, data word width; must be a multiple of 8
ADDR_W, 8, address port width
DEPTH, 16, number of words; must be <= 2**ADDR_W
RD_LAT, 1, cycles from ACCESS to read ack; range 1..8

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous, active-low reset
req  in  1  master request; held high until ack is seen, then dropped
cmd  in  1  1 = write, 0 = read; stable while req is high
addr  in  ADDR_W  word address; stable while req is high
wdata  in  DATA_W  write data
be  in  DATA_W/8  byte enables for writes; bit i gates wdata[8i+7:8i]
ack  out  1  transaction done; held until req falls
rdata  out  DATA_W  read data; valid when ack=1 and cmd=0 and err=0; holds afterwards
err  out  1  address out of range; qualified by ack

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low.
- Reset values: when rst_n=0 at a posedge, state<=IDLE, ack<=0, err<=0, rdata<=0, latency counter<=0. Memory contents are untouched unless the optional feature is enabled.
- State IDLE:
  - req=1 -> ACCESS.
  - Otherwise stay.
- State ACCESS: cmd, addr, wdata and be are sampled at this edge.
  - Out of range (addr >= DEPTH): no memory change, rdata<=0, err<=1, ack<=1, next state RET.
  - Write: for each i with be[i]=1, mem[addr] byte i <= wdata byte i. Then ack<=1, next state RET. be=0 is legal: ack with no change.
  - Read: rdata<=mem[addr].
    - RD_LAT=1: ack<=1, next state RET.
    - RD_LAT>1: counter<=RD_LAT-1, next state WAIT.
- State WAIT:
  - Counter decrements each cycle.
  - When counter==1: ack<=1, next state RET.
  - rdata is already stable in WAIT.
- State RET:
  - req=0 -> ack<=0, err<=0, next state IDLE.
  - Otherwise hold.
- Latency from the cycle req is first sampled high:
  - Write or error: ack high 2 edges later.
  - Read: ack high RD_LAT+1 edges later.
  - ack falls 1 edge after req is sampled low.
- Back-to-back transactions: minimum 1 IDLE cycle between them. A req already high in IDLE starts the next access.
- req dropped early (before ack): the transaction still completes. ack pulses high for exactly 1 cycle, then RET returns to IDLE.
- Reset mid-transaction: aborts to IDLE and ack drops. A write already committed at an earlier edge stays committed.
- Address width: address bits are never masked. Full ADDR_W compare against DEPTH; no wrap-around aliasing.

Optional Feature:
- Macro: MEM_SLAVE_P_CLR_EN.
- Defined:
  - Reset release enters state CLEAR instead of IDLE.
  - CLEAR writes 0 to one word per cycle, index 0..DEPTH-1, DEPTH cycles total, then goes to IDLE.
  - req is ignored during CLEAR and ack stays 0.
  - Reset asserted during CLEAR restarts the sweep from word 0.
- Undefined: no CLEAR state. Memory keeps its contents across reset; simulation initial contents are X.

Test Plan:
- Write then read (defaults, RD_LAT=2): write addr=3 data=0xDEADBEEF be=0xF -> ack 2 edges after req, err=0. Read addr=3 -> ack 3 edges after req, rdata=0xDEADBEEF.
- Byte enables: preload addr=5 with 0x11223344, write 0xAABBCCDD be=0x5 -> read returns 0x11BB33DD.
- Out of range: read addr=16 -> ack with err=1, rdata=0. Write addr=200 -> err=1, and reads of all addrs 0..15 are unchanged.
- Handshake: req held 5 cycles after ack -> ack stays high until 1 edge after req falls. Early req drop in WAIT -> ack is a 1-cycle pulse and the FSM returns to IDLE.
- Reset mid-read: rst_n=0 in WAIT -> next edge ack=0, err=0, rdata=0. A new read after release completes normally.
- With MEM_SLAVE_P_CLR_EN: write 0xFFFFFFFF to addrs 0..15, then reset. A req asserted immediately gets no ack for 16 cycles, then all reads return 0.
